// File: rtl/usb_fs_pkg.sv
// Shared types and constants for the USB line receiver.
//   line_state_e : decoded bus state from the synchronised dp/dn pair
//   rx_state_e   : receiver FSM states
//   decode_line  : maps a dp/dn pair to a line state, honouring the
//                  low-speed J/K swap
package usb_fs_pkg;

  typedef enum logic [1:0] {LINE_J, LINE_K, LINE_SE0, LINE_SE1} line_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_SYNC, RX_PAYLOAD, RX_EOP} rx_state_e;

  localparam int unsigned SYNC_ZEROS_MIN = 5;
  localparam int unsigned SYNC_MAX_BITS  = 8;

  function automatic line_state_e decode_line(input logic dp, input logic dn,
                                              input logic low_speed);
    line_state_e ls;
    case ({dp, dn})
      2'b00:   ls = LINE_SE0;
      2'b11:   ls = LINE_SE1;
      2'b10:   ls = low_speed ? LINE_K : LINE_J;
      default: ls = low_speed ? LINE_J : LINE_K;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/usb_rx_dpll.sv
// Input synchroniser and bit-phase recovery.
//   clk48, reset : clock and synchronous active-low reset
//   dp, dn       : raw pad inputs
//   line_state   : synchronised J/K/SE0/SE1
//   j_to_k       : synchronised line just moved from J to K
//   sample       : this cycle is the mid-bit sample point
module usb_rx_dpll import usb_fs_pkg::*; #(
  parameter int unsigned OVERSAMPLE = 4,
  parameter bit          LOW_SPEED  = 1'b0
) (
  input  logic        clk48,
  input  logic        reset,
  input  logic        dp,
  input  logic        dn,
  output line_state_e line_state,
  output logic        j_to_k,
  output logic        sample
);

  localparam int unsigned PH_W = $clog2(OVERSAMPLE);
  // Pad levels of an idle (J) bus, so reset does not fake an edge.
  localparam logic IDLE_DP = ~LOW_SPEED;
  localparam logic IDLE_DN = LOW_SPEED;

  logic [1:0]      dp_sync_q, dp_sync_d, dn_sync_q, dn_sync_d;
  line_state_e     line_prev_q, line_prev_d;
  logic [PH_W-1:0] ph_q, ph_d, ph_cur;
  logic            line_edge;

  always_comb begin
    dp_sync_d   = {dp_sync_q[0], dp};
    dn_sync_d   = {dn_sync_q[0], dn};
    line_state  = decode_line(dp_sync_q[1], dn_sync_q[1], LOW_SPEED);
    line_prev_d = line_state;
    line_edge   = (line_state != line_prev_q);
    j_to_k      = (line_state == LINE_K) && (line_prev_q == LINE_J);
    // Realign on every line change. The phase is only consumed outside
    // IDLE, and IDLE is only left on an edge, so realigning in IDLE too
    // is equivalent and keeps this block independent of the FSM.
    ph_cur      = line_edge ? '0 : ph_q;
    sample      = (ph_cur == PH_W'(OVERSAMPLE / 2));
    ph_d        = (ph_cur == PH_W'(OVERSAMPLE - 1)) ? '0 : ph_cur + 1'b1;
  end

  always_ff @(posedge clk48) begin
    if (!reset) begin
      dp_sync_q   <= {2{IDLE_DP}};
      dn_sync_q   <= {2{IDLE_DN}};
      line_prev_q <= LINE_J;
      ph_q        <= '0;
    end else begin
      dp_sync_q   <= dp_sync_d;
      dn_sync_q   <= dn_sync_d;
      line_prev_q <= line_prev_d;
      ph_q        <= ph_d;
    end
  end

endmodule

// File: rtl/usb_rx_decoder.sv
// USB line receiver: SYNC detect, NRZI decode, bit unstuffing, EOP and
// line-error detection, bus-reset detection.
//   clk48, reset : clock and synchronous active-low reset
//   dp, dn       : raw pad inputs
//   bit_out      : decoded payload bit, qualified by bit_valid
//   bit_valid    : one strobe per payload bit
//   bus_sop      : pulse when SYNC completes
//   bus_eop      : pulse on SE0 followed by J
//   bus_reset    : level while SE0 has lasted RESET_CLKS cycles
//   stuff_err    : pulse on a 1 where a stuffed 0 was due
//   line_err     : pulse on SE1, K during EOP, or bad/long SYNC
module usb_rx_decoder import usb_fs_pkg::*; #(
  parameter int unsigned OVERSAMPLE = 4,
  parameter int unsigned STUFF_LEN  = 6,
  parameter int unsigned RESET_CLKS = 120000,
  parameter bit          LOW_SPEED  = 1'b0
) (
  input  logic clk48,
  input  logic reset,
  input  logic dp,
  input  logic dn,
  output logic bit_out,
  output logic bit_valid,
  output logic bus_sop,
  output logic bus_eop,
  output logic bus_reset,
  output logic stuff_err,
  output logic line_err
);

  localparam int unsigned RC_W = $clog2(RESET_CLKS + 1);

  line_state_e line_state;
  logic        j_to_k, sample;

  usb_rx_dpll #(.OVERSAMPLE(OVERSAMPLE), .LOW_SPEED(LOW_SPEED)) u_dpll (
    .clk48      (clk48),
    .reset      (reset),
    .dp         (dp),
    .dn         (dn),
    .line_state (line_state),
    .j_to_k     (j_to_k),
    .sample     (sample)
  );

  rx_state_e       state_q, state_d;
  logic [2:0]      sync_cnt_q, sync_cnt_d, ones_q, ones_d;
  logic [1:0]      se0_cnt_q, se0_cnt_d;
  logic            prev_k_q, prev_k_d;
  logic            sync_first_q, sync_first_d;
  logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
  logic            bit_out_q, bit_out_d, bit_valid_q, bit_valid_d;
  logic            sop_q, sop_d, eop_q, eop_d;
  logic            stuff_err_q, stuff_err_d, line_err_q, line_err_d;
  logic            is_j, is_k, is_se0, is_jk, dec, bus_reset_w;

  assign bus_reset_w = (rst_cnt_q == RC_W'(RESET_CLKS));

  always_comb begin
    is_j   = (line_state == LINE_J);
    is_k   = (line_state == LINE_K);
    is_se0 = (line_state == LINE_SE0);
    is_jk  = is_j | is_k;
    dec    = (is_k == prev_k_q);   // NRZI: no transition decodes as 1

    state_d      = state_q;
    sync_cnt_d   = sync_cnt_q;
    ones_d       = ones_q;
    se0_cnt_d    = se0_cnt_q;
    sync_first_d = sync_first_q;
    prev_k_d     = (sample && is_jk) ? is_k : prev_k_q;
    bit_out_d    = 1'b0;
    bit_valid_d  = 1'b0;
    sop_d        = 1'b0;
    eop_d        = 1'b0;
    stuff_err_d  = 1'b0;
    line_err_d   = 1'b0;

    rst_cnt_d = '0;
    if (is_se0) rst_cnt_d = bus_reset_w ? rst_cnt_q : rst_cnt_q + 1'b1;

    case (state_q)
      RX_IDLE: begin
        if (j_to_k) begin
          state_d      = RX_SYNC;
          sync_cnt_d   = '0;
          prev_k_d     = 1'b1;
          sync_first_d = 1'b1;
        end
      end
      RX_SYNC: begin
        if (sample) begin
          if (!is_jk) begin
            state_d = RX_IDLE;
          end else if (sync_first_q) begin
            // The K that opened SYNC is its own first sample; it only
            // seeds the NRZI reference and is not a decoded bit.
            sync_first_d = 1'b0;
          end else if (!dec) begin
            if (sync_cnt_q == 3'(SYNC_MAX_BITS - 1)) begin
              line_err_d = 1'b1;
              state_d    = RX_IDLE;
            end else begin
              sync_cnt_d = sync_cnt_q + 3'd1;
            end
          end else if (sync_cnt_q >= 3'(SYNC_ZEROS_MIN)) begin
            state_d = RX_PAYLOAD;
            sop_d   = 1'b1;
            ones_d  = 3'd1;   // SYNC's closing 1 counts toward stuffing
          end else begin
            line_err_d = 1'b1;
            state_d    = RX_IDLE;
          end
        end
      end
      RX_PAYLOAD: begin
        if (sample) begin
          if (is_se0) begin
            state_d   = RX_EOP;
            se0_cnt_d = 2'd1;
          end else if (!is_jk) begin
            line_err_d = 1'b1;
            state_d    = RX_IDLE;
          end else if (ones_q == 3'(STUFF_LEN)) begin
            if (dec) begin
              stuff_err_d = 1'b1;
              state_d     = RX_IDLE;
            end else begin
              ones_d = '0;
            end
          end else begin
            bit_out_d   = dec;
            bit_valid_d = 1'b1;
            ones_d      = dec ? ones_q + 3'd1 : 3'd0;
          end
        end
      end
      RX_EOP: begin
        if (sample) begin
          if (is_se0) begin
            se0_cnt_d = (se0_cnt_q == 2'd3) ? 2'd3 : se0_cnt_q + 2'd1;
          end else if (is_j) begin
            eop_d   = 1'b1;
            state_d = RX_IDLE;
          end else begin
            line_err_d = 1'b1;
            state_d    = RX_IDLE;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase

    if (bus_reset_w) begin
      state_d     = RX_IDLE;
      eop_d       = 1'b0;
      stuff_err_d = 1'b0;
      line_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk48) begin
    if (!reset) begin
      state_q      <= RX_IDLE;
      sync_cnt_q   <= '0;
      ones_q       <= '0;
      se0_cnt_q    <= '0;
      prev_k_q     <= 1'b0;
      sync_first_q <= 1'b0;
      rst_cnt_q    <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      stuff_err_q  <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_cnt_q   <= sync_cnt_d;
      ones_q       <= ones_d;
      se0_cnt_q    <= se0_cnt_d;
      prev_k_q     <= prev_k_d;
      sync_first_q <= sync_first_d;
      rst_cnt_q    <= rst_cnt_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      stuff_err_q  <= stuff_err_d;
      line_err_q   <= line_err_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign bus_sop   = sop_q;
  assign bus_eop   = eop_q;
  assign bus_reset = bus_reset_w;
  assign stuff_err = stuff_err_q;
  assign line_err  = line_err_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Bench for usb_rx_decoder: a full-speed and a low-speed instance share the
// clock and reset; packets are built from bits by a bench-side encoder.
module tb_usb_rx_decoder;

  localparam int FS_OS    = 4;
  localparam int LS_OS    = 32;
  localparam int RST_CLKS = 400;
  localparam int STUFF    = 6;
  localparam logic [1:0] SJ = 2'd0, SK = 2'd1, S0 = 2'd2, S1 = 2'd3;

  logic clk48 = 1'b0;
  always #5 clk48 = ~clk48;

  logic reset;
  logic fs_dp, fs_dn, ls_dp, ls_dn;
  logic fs_bit, fs_vld, fs_sop, fs_eop, fs_brst, fs_stf, fs_lin;
  logic ls_bit, ls_vld, ls_sop, ls_eop, ls_brst, ls_stf, ls_lin;

  usb_rx_decoder #(.OVERSAMPLE(FS_OS), .STUFF_LEN(STUFF), .RESET_CLKS(RST_CLKS),
                   .LOW_SPEED(1'b0)) u_fs (
    .clk48(clk48), .reset(reset), .dp(fs_dp), .dn(fs_dn),
    .bit_out(fs_bit), .bit_valid(fs_vld), .bus_sop(fs_sop), .bus_eop(fs_eop),
    .bus_reset(fs_brst), .stuff_err(fs_stf), .line_err(fs_lin));

  usb_rx_decoder #(.OVERSAMPLE(LS_OS), .STUFF_LEN(STUFF), .RESET_CLKS(RST_CLKS),
                   .LOW_SPEED(1'b1)) u_ls (
    .clk48(clk48), .reset(reset), .dp(ls_dp), .dn(ls_dn),
    .bit_out(ls_bit), .bit_valid(ls_vld), .bus_sop(ls_sop), .bus_eop(ls_eop),
    .bus_reset(ls_brst), .stuff_err(ls_stf), .line_err(ls_lin));

  // ---------------- event monitor (index 0 = FS, 1 = LS) ----------------
  int   nbit[2], nsop[2], neop[2], nstf[2], nlin[2];
  logic blog[2][4096];

  always @(negedge clk48) begin
    if (fs_vld) begin blog[0][nbit[0] % 4096] <= fs_bit; nbit[0] <= nbit[0] + 1; end
    if (ls_vld) begin blog[1][nbit[1] % 4096] <= ls_bit; nbit[1] <= nbit[1] + 1; end
    if (fs_sop) nsop[0] <= nsop[0] + 1;
    if (ls_sop) nsop[1] <= nsop[1] + 1;
    if (fs_eop) neop[0] <= neop[0] + 1;
    if (ls_eop) neop[1] <= neop[1] + 1;
    if (fs_stf) nstf[0] <= nstf[0] + 1;
    if (ls_stf) nstf[1] <= nstf[1] + 1;
    if (fs_lin) nlin[0] <= nlin[0] + 1;
    if (ls_lin) nlin[1] <= nlin[1] + 1;
  end

  int errors = 0, checks = 0;
  int b_bit, b_sop, b_eop, b_stf, b_lin;
  logic [1:0] sq[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk48);
    #1;
  endtask

  // J = dp high at full speed; low speed swaps the J/K pins.
  task automatic set_line(input bit ls, input logic [1:0] sym);
    logic p, n;
    case (sym)
      SJ:      begin p = 1'b1; n = 1'b0; end
      SK:      begin p = 1'b0; n = 1'b1; end
      S0:      begin p = 1'b0; n = 1'b0; end
      default: begin p = 1'b1; n = 1'b1; end
    endcase
    if (ls && (sym == SJ || sym == SK)) {p, n} = {n, p};
    if (ls) begin ls_dp = p; ls_dn = n; end
    else    begin fs_dp = p; fs_dn = n; end
  endtask

  task automatic drive_range(input bit ls, input int from, input int to, input bit jit);
    int os;
    os = ls ? LS_OS : FS_OS;
    for (int k = from; k < to; k++) begin
      set_line(ls, sq[k]);
      cyc(jit ? ((k % 2) ? os + 1 : os - 1) : os);
    end
  endtask

  task automatic push_sync();
    sq.delete();
    sq.push_back(SK); sq.push_back(SJ); sq.push_back(SK); sq.push_back(SJ);
    sq.push_back(SK); sq.push_back(SJ); sq.push_back(SK); sq.push_back(SK);
  endtask

  // Encoder: NRZI with a stuffed 0 after STUFF consecutive 1s (SYNC's final
  // 1 included). With bad set, the first stuffed 0 becomes a 1 and the
  // packet is cut there. dlv = payload bits that precede the cut.
  task automatic encode(input int n, input logic [15:0] bits, input bit bad,
                        output int dlv, output bit hit);
    logic [1:0] cur;
    int ones;
    push_sync();
    cur = SK; ones = 1; dlv = 0; hit = 1'b0;
    for (int i = 0; i < n && !hit; i++) begin
      if (ones == STUFF) begin
        if (bad) begin sq.push_back(cur); hit = 1'b1; end
        else begin cur = (cur == SJ) ? SK : SJ; sq.push_back(cur); ones = 0; end
      end
      if (!hit) begin
        if (!bits[i]) cur = (cur == SJ) ? SK : SJ;
        sq.push_back(cur);
        ones = bits[i] ? ones + 1 : 0;
        dlv++;
      end
    end
    sq.push_back(S0); sq.push_back(S0); sq.push_back(SJ);
  endtask

  task automatic snap(input bit ls);
    b_bit = nbit[ls]; b_sop = nsop[ls]; b_eop = neop[ls];
    b_stf = nstf[ls]; b_lin = nlin[ls];
  endtask

  task automatic check_pkt(input bit ls, input string name, input int e_sop,
                           input int e_n, input logic [15:0] e_bits,
                           input int e_eop, input int e_stf, input int e_lin);
    logic [15:0] got;
    int cnt;
    got = '0;
    cnt = nbit[ls] - b_bit;
    for (int i = 0; i < cnt && i < 16; i++) got[i] = blog[ls][(b_bit + i) % 4096];
    check($sformatf("%s sop", name),   nsop[ls] - b_sop, e_sop);
    check($sformatf("%s nbits", name), cnt, e_n);
    check($sformatf("%s bits", name),  int'(got), int'(e_bits));
    check($sformatf("%s eop", name),   neop[ls] - b_eop, e_eop);
    check($sformatf("%s stuff", name), nstf[ls] - b_stf, e_stf);
    check($sformatf("%s lineerr", name), nlin[ls] - b_lin, e_lin);
  endtask

  task automatic idle(input bit ls, input int bits_n);
    set_line(ls, SJ);
    cyc(bits_n * (ls ? LS_OS : FS_OS));
  endtask

  typedef struct {
    bit ls; int n; logic [15:0] bits; bit jit; bit bad;
    int e_n; logic [15:0] e_bits; int e_eop; int e_stf;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int dlv;
    bit hit;
    logic [15:0] rb, eb;
    bit rls, rjit, rbad;
    int rn;

    tbl[0] = '{1'b0,  8, 16'h00A5, 1'b0, 1'b0,  8, 16'h00A5, 1, 0};
    tbl[1] = '{1'b0,  7, 16'h007F, 1'b0, 1'b0,  7, 16'h007F, 1, 0};
    tbl[2] = '{1'b0,  7, 16'h007F, 1'b0, 1'b1,  5, 16'h001F, 0, 1};
    tbl[3] = '{1'b0, 16, 16'hF0E5, 1'b1, 1'b0, 16, 16'hF0E5, 1, 0};
    tbl[4] = '{1'b0, 16, 16'hFFF0, 1'b1, 1'b0, 16, 16'hFFF0, 1, 0};
    tbl[5] = '{1'b1,  8, 16'h00A5, 1'b0, 1'b0,  8, 16'h00A5, 1, 0};

    reset = 1'b0;
    set_line(0, SJ);
    set_line(1, SJ);
    cyc(5);
    check("reset outs fs", int'({fs_bit, fs_vld, fs_sop, fs_eop, fs_brst, fs_stf, fs_lin}), 0);
    check("reset outs ls", int'({ls_bit, ls_vld, ls_sop, ls_eop, ls_brst, ls_stf, ls_lin}), 0);
    reset = 1'b1;
    cyc(10);

    // ---- table-driven packets ----
    for (int t = 0; t < 6; t++) begin
      idle(tbl[t].ls, 2);
      encode(tbl[t].n, tbl[t].bits, tbl[t].bad, dlv, hit);
      snap(tbl[t].ls);
      drive_range(tbl[t].ls, 0, sq.size(), tbl[t].jit);
      idle(tbl[t].ls, 4);
      check_pkt(tbl[t].ls, $sformatf("vec%0d", t), 1, tbl[t].e_n, tbl[t].e_bits,
                tbl[t].e_eop, tbl[t].e_stf, 0);
    end

    // ---- SE1 inside payload ----
    push_sync(); sq.push_back(SK); sq.push_back(SJ); sq.push_back(S1); sq.push_back(SJ);
    idle(0, 2); snap(0); drive_range(0, 0, sq.size(), 0); idle(0, 4);
    check_pkt(0, "se1", 1, 2, 16'h0001, 0, 0, 1);

    // ---- K where EOP expects J ----
    push_sync(); sq.push_back(SJ); sq.push_back(S0); sq.push_back(S0);
    sq.push_back(SK); sq.push_back(SJ);
    idle(0, 2); snap(0); drive_range(0, 0, sq.size(), 0); idle(0, 4);
    check_pkt(0, "k_in_eop", 1, 1, 16'h0000, 0, 0, 1);

    // ---- SYNC closed after too few zeros ----
    sq.delete(); sq.push_back(SK); sq.push_back(SJ); sq.push_back(SK);
    sq.push_back(SK); sq.push_back(SJ);
    idle(0, 2); snap(0); drive_range(0, 0, sq.size(), 0); idle(0, 4);
    check_pkt(0, "short_sync", 0, 0, 16'h0000, 0, 0, 1);

    // ---- SYNC that never closes: 8th zero times out ----
    sq.delete(); sq.push_back(SK);
    for (int i = 0; i < 4; i++) begin sq.push_back(SJ); sq.push_back(SK); end
    sq.push_back(SJ);
    idle(0, 2); snap(0); drive_range(0, 0, sq.size(), 0); idle(0, 4);
    check_pkt(0, "sync_timeout", 0, 0, 16'h0000, 0, 0, 1);

    // ---- bus reset entered from inside a packet ----
    push_sync(); sq.push_back(SK); sq.push_back(SJ); sq.push_back(SJ);
    idle(0, 2); snap(0); drive_range(0, 0, sq.size(), 0);
    set_line(0, S0);
    cyc(RST_CLKS + 1);
    check("busrst before", int'(fs_brst), 0);
    cyc(1);
    check("busrst rise", int'(fs_brst), 1);
    cyc(50);
    check("busrst hold", int'(fs_brst), 1);
    set_line(0, SJ);
    cyc(2);
    check("busrst j+2", int'(fs_brst), 1);
    cyc(1);
    check("busrst fall", int'(fs_brst), 0);
    idle(0, 4);
    check_pkt(0, "busrst pkt", 1, 3, 16'h0005, 0, 0, 0);

    // ---- low speed: reset applied mid-payload, released at idle ----
    encode(8, 16'h00A5, 1'b0, dlv, hit);
    idle(1, 2); snap(1);
    drive_range(1, 0, 12, 0);
    reset = 1'b0;
    drive_range(1, 12, sq.size(), 0);
    check("ls in reset outs", int'({ls_bit, ls_vld, ls_sop, ls_eop, ls_brst, ls_stf, ls_lin}), 0);
    idle(1, 2);
    reset = 1'b1;
    idle(1, 4);
    check_pkt(1, "ls midreset", 1, 4, 16'h0005, 0, 0, 0);

    // ---- random packets vs encoder-side expectations ----
    for (int r = 0; r < 24; r++) begin
      rls  = ($urandom_range(0, 4) == 0);
      rjit = !rls && ($urandom_range(0, 1) == 1);
      rbad = ($urandom_range(0, 3) == 0);
      rn   = $urandom_range(1, 16);
      rb   = '0;
      for (int i = 0; i < rn; i++) rb[i] = ($urandom_range(0, 3) != 0);
      encode(rn, rb, rbad, dlv, hit);
      eb = '0;
      for (int i = 0; i < dlv; i++) eb[i] = rb[i];
      idle(rls, 2); snap(rls);
      drive_range(rls, 0, sq.size(), rjit);
      idle(rls, 4);
      check_pkt(rls, $sformatf("rand%0d", r), 1, dlv, eb,
                hit ? 0 : 1, hit ? 1 : 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
